bcd_scan_display: RTL
=====================

# bcd_scan_display

Parametrised successor to the single-digit BCD/7-segment path on the Nexys4 DDR board. Accepts an unsigned binary value of WIDTH bits, converts it to DIGITS BCD digits with a sequential shift-add-3 (double-dabble) engine, and drives a time-multiplexed 8-anode common-anode display. It adds three things the single-digit path lacked:

- overflow detection with a dash pattern,
- leading-zero blanking,
- a load/done handshake.

## Interface

Parameters:
- WIDTH, 8 — binary input width; legal 4..32.
- DIGITS, 4 — displayed BCD digits; legal 1..8.
- REFRESH_DIV, 100000 — clk cycles per digit slot; legal ≥2 (benches use 4).
- BLANK_LZ, 1 — 1 enables leading-zero blanking.

Ports:
- clk — input, 1 — board clock, all logic on rising edge.
- reset_n — input, 1 — asynchronous, active-low reset.
- v — input, WIDTH — unsigned binary value; sampled only when a load is accepted.
- load — input, 1 — conversion request; level-sampled.
- busy — output, 1 — high while conversion iterations run.
- done — output, 1 — one-cycle pulse when the display register updates.
- z — output, 1 — overflow flag: value > 10^DIGITS − 1; held until next done or reset.
- an — output, 8 — anodes, active-low.
- seg — output, 7 — segments {g,f,e,d,c,b,a}, active-low.
- dp — output, 1 — decimal point, constant 1 (off).

## Operation

- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - load=1 captures v into the shift register, clears the BCD accumulator and the sticky overflow bit, sets the iteration count to WIDTH, and moves to SHIFT.
  - load=0 stays in IDLE.
- SHIFT, one iteration per cycle:
  - Every BCD nibble ≥5 gets +3.
  - The {BCD, binary} register then shifts left by 1.
  - A 1 shifted out of the top nibble sets the sticky overflow bit.
  - After the WIDTH-th iteration, go to DONE.
- DONE, exactly one cycle:
  - Display register ← BCD result.
  - z ← sticky overflow bit.
  - done=1.
  - Return to IDLE.
- load is ignored in SHIFT and DONE. Changes on v after acceptance do not affect the result.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV−1.
  - On wrap, the digit index advances modulo DIGITS (0→1→…→DIGITS−1→0).
  - The scan runs continuously, independent of the FSM.
- Anode for the active digit i:
  - an[i]=0, all other bits 1.
  - an[7:DIGITS] is always 1.
- Blanking: if BLANK_LZ=1, i>0, z=0, and display digits i..DIGITS−1 are all zero, then an[i] stays 1 for that slot. Digit 0 is never blanked.
- Overflow display: if z=1, every active slot shows dash (seg=0111111), with no blanking.
- Segment codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Nibbles >9 cannot occur.
- an and seg are combinational from the registered digit index, display register and z.

## Timing

- Reset values (asynchronous, immediate on reset_n=0):
  - FSM, counters and registers: state=IDLE, display register=0, z=0, busy=0, done=0, digit index=0, refresh counter=0.
  - Resulting outputs: an=11111110, seg=1000000, dp=1.
- Load latency:
  - load is high at edge k and accepted.
  - busy=1 for cycles k+1..k+WIDTH.
  - done=1 in cycle k+WIDTH+1, and the new display and z are visible from that same cycle.
  - The earliest next accepted load is at edge k+WIDTH+2; load held high continuously therefore re-converts every WIDTH+2 cycles.
- Reset mid-conversion: aborts the conversion, clears the display to 0, and no done is produced.
- Digit index changes every REFRESH_DIV cycles. A full frame is DIGITS×REFRESH_DIV cycles.
- A display update mid-slot takes effect immediately on seg/an. Scan phase is unaffected.

## Test plan

1. Reset: assert reset_n=0 mid-run -> an=11111110, seg=1000000, z=0, busy=0, done=0 immediately; the scan restarts at digit 0 after release.
2. WIDTH=8, DIGITS=4, REFRESH_DIV=4, v=255, load pulse:
   - busy high exactly 8 cycles, then done for 1 cycle, z=0.
   - The scan shows digit0 seg=0010010 (5), digit1 0010010 (5), digit2 0100100 (2); digit3 slot has an=11111111 (blanked).
3. v=0 -> only the digit0 slot is lit, showing 1000000; the slots for digits 1..3 have an=11111111. With BLANK_LZ=0, all four slots show 1000000.
4. DIGITS=2, WIDTH=8:
   - v=100 -> z=1, both slots seg=0111111.
   - Then v=99 -> z=0, both slots show 0010000.
5. Load held high; v changed from 37 to 200 during SHIFT -> result is 37 (done pulses every 10 cycles for WIDTH=8); a load during DONE is ignored.
6. reset_n pulsed low in the 4th SHIFT cycle after a load of v=123 -> no done; display 0; a following load of v=123 completes normally, showing 1, 2, 3.

Source files
------------

// File: rtl/bcd_scan_display.sv
// Binary to BCD converter (sequential double-dabble) feeding a
// time-multiplexed 8-anode common-anode 7-segment display.
module bcd_scan_display #(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_LZ    = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] v,
  input  logic             load,
  output logic             busy,
  output logic             done,
  output logic             z,
  output logic [7:0]       an,
  output logic [6:0]       seg,
  output logic             dp
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int RW = (REFRESH_DIV > 1) ?
                      $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] bin_d;
  logic [BW-1:0]    bcd_q;
  logic [BW-1:0]    bcd_d;
  logic [BW-1:0]    adj;
  logic             ovf_q;
  logic             ovf_d;
  logic [CW-1:0]    cnt_q;
  logic [BW-1:0]    disp_q;
  logic             z_q;
  logic             busy_q;
  logic             done_q;
  logic [RW-1:0]    rc_q;
  logic [IW-1:0]    idx_q;

  logic [DIGITS-1:0] hi_nz;
  logic              hi_nz_sel;
  logic [3:0]        digit;
  logic              blank;
  logic [6:0]        seg_dec;

  function automatic logic [3:0] add3(
    input logic [3:0] n
  );
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // One double-dabble iteration: correct every nibble,
  // then shift {bcd, bin} left; a 1 leaving the top
  // nibble means the value does not fit in DIGITS.
  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      adj[4*i +: 4] = add3(bcd_q[4*i +: 4]);
    end
    bcd_d = {adj[BW-2:0], bin_q[WIDTH-1]};
    bin_d = {bin_q[WIDTH-2:0], 1'b0};
    ovf_d = ovf_q | adj[BW-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      disp_q  <= '0;
      z_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (load) begin
            bin_q   <= v;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= CW'(WIDTH);
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          bin_q <= bin_d;
          bcd_q <= bcd_d;
          ovf_q <= ovf_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            disp_q  <= bcd_d;
            z_q     <= ovf_d;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rc_q  <= '0;
      idx_q <= '0;
    end else if (rc_q == RW'(REFRESH_DIV - 1)) begin
      rc_q <= '0;
      if (idx_q == IW'(DIGITS - 1)) begin
        idx_q <= '0;
      end else begin
        idx_q <= idx_q + IW'(1);
      end
    end else begin
      rc_q <= rc_q + RW'(1);
    end
  end

  // hi_nz[i]: some digit at position i or above is nonzero.
  always_comb begin
    hi_nz = '0;
    hi_nz[DIGITS-1] = |disp_q[BW-1 -: 4];
    for (int i = DIGITS - 2; i >= 0; i--) begin
      hi_nz[i] = hi_nz[i+1] | (|disp_q[4*i +: 4]);
    end
  end

  always_comb begin
    digit     = '0;
    hi_nz_sel = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (IW'(i) == idx_q) begin
        digit     = disp_q[4*i +: 4];
        hi_nz_sel = hi_nz[i];
      end
    end
  end

  assign blank = (BLANK_LZ != 0) && (idx_q != '0) &&
                 !z_q && !hi_nz_sel;

  always_comb begin
    an = 8'hFF;
    for (int i = 0; i < DIGITS; i++) begin
      if (IW'(i) == idx_q && !blank) begin
        an[i] = 1'b0;
      end
    end
  end

  always_comb begin
    case (digit)
      4'd0:    seg_dec = 7'b1000000;
      4'd1:    seg_dec = 7'b1111001;
      4'd2:    seg_dec = 7'b0100100;
      4'd3:    seg_dec = 7'b0110000;
      4'd4:    seg_dec = 7'b0011001;
      4'd5:    seg_dec = 7'b0010010;
      4'd6:    seg_dec = 7'b0000010;
      4'd7:    seg_dec = 7'b1111000;
      4'd8:    seg_dec = 7'b0000000;
      4'd9:    seg_dec = 7'b0010000;
      default: seg_dec = 7'b1111111;
    endcase
  end

  assign seg  = z_q ? 7'b0111111 : seg_dec;
  assign busy = busy_q;
  assign done = done_q;
  assign z    = z_q;
  assign dp   = 1'b1;

endmodule
